// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: ordered DIGITS x DW digit entry (backspace, clear, range check) released via valid/ready commit; DIGIT_UNIQUE_EN refuses repeated digits
module digit_entry_buffer #(
  parameter int DIGITS = 4,
  parameter int DW = 4,
  parameter int unsigned MAX_DIGIT = 9,
  parameter logic [DW-1:0] INIT_VAL = {DW{1'b1}},
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_digit,
  input  logic                 in_back,
  input  logic                 in_clear,
  input  logic                 commit,
  input  logic                 out_ready,
  output logic [DIGITS*DW-1:0] out_digits,
  output logic                 out_valid,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 reject
);
  typedef enum logic [1:0] {FILL, FULL, HOLD} state_t;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  state_t state;
  logic dup, ok;
`ifdef DIGIT_UNIQUE_EN
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      dup = dup | ((CW'(i) < count) && (out_digits[i*DW +: DW] == in_digit));
  end
`else
  assign dup = 1'b0;
`endif
  assign ok = (32'(in_digit) <= MAX_DIGIT) && !dup;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_digits <= {DIGITS{INIT_VAL}};
      count <= '0;
      full <= 1'b0;
      out_valid <= 1'b0;
      reject <= 1'b0;
      state <= FILL;
    end else if (!ce) begin
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        FILL, FULL: begin
          if (in_clear) begin
            out_digits <= {DIGITS{INIT_VAL}};
            count <= '0;
            full <= 1'b0;
            state <= FILL;
          end else if (in_back) begin
            if (count != '0) begin
              out_digits[(count - 1'b1)*DW +: DW] <= INIT_VAL;
              count <= count - 1'b1;
              full <= 1'b0;
              state <= FILL;
            end
          end else begin
            if (in_valid) begin
              if (state == FILL && ok) begin
                out_digits[count*DW +: DW] <= in_digit;
                count <= count + 1'b1;
                full <= count == LAST;
                state <= count == LAST ? FULL : FILL;
              end else begin
                reject <= 1'b1;
              end
            end else if (commit && state == FILL) begin
              reject <= 1'b1;
            end
            if (commit && state == FULL) begin
              out_valid <= 1'b1;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_digits <= {DIGITS{INIT_VAL}};
            count <= '0;
            full <= 1'b0;
            out_valid <= 1'b0;
            state <= FILL;
          end else begin
            reject <= in_valid | in_back | commit;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer: vector table, corner sequences and randomized model check of digit_entry_buffer
module tb_digit_entry_buffer;
  localparam int D = 4;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst, ce, in_valid, in_back, in_clear, commit, out_ready;
  logic [W-1:0] in_digit;
  logic [D*W-1:0] out_digits;
  logic out_valid, full, reject;
  logic [2:0] count;
  int vecs = 0;
  int bad = 0;
  typedef struct {
    string nm;
    logic r, e, v;
    logic [3:0] d;
    logic b, cl, cm, rd;
    logic [15:0] xd;
    logic xv;
    logic [2:0] xc;
    logic xf, xr;
  } vec_t;
  vec_t tbl[$];
  int q[$];
  bit m_hold, m_rej;
  always #5 clk = ~clk;
  digit_entry_buffer dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_digit(in_digit),
    .in_back(in_back), .in_clear(in_clear), .commit(commit), .out_ready(out_ready),
    .out_digits(out_digits), .out_valid(out_valid), .count(count), .full(full), .reject(reject)
  );
  task automatic drive(input logic r, e, v, input logic [3:0] d, input logic b, cl, cm, rd);
    @(negedge clk);
    rst = r; ce = e; in_valid = v; in_digit = d; in_back = b; in_clear = cl; commit = cm; out_ready = rd;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [15:0] xd, input logic xv, input logic [2:0] xc, input logic xf, xr);
    vecs++;
    if ({out_digits, out_valid, count, full, reject} !== {xd, xv, xc, xf, xr}) begin
      bad++;
      $display("FAIL %s: got digits=%h valid=%b count=%0d full=%b reject=%b, want digits=%h valid=%b count=%0d full=%b reject=%b",
               nm, out_digits, out_valid, count, full, reject, xd, xv, xc, xf, xr);
    end
  endtask
  function automatic void add(string nm, logic r, e, v, logic [3:0] d, logic b, cl, cm, rd,
                              logic [15:0] xd, logic xv, logic [2:0] xc, logic xf, xr);
    vec_t t;
    t.nm = nm; t.r = r; t.e = e; t.v = v; t.d = d; t.b = b; t.cl = cl; t.cm = cm; t.rd = rd;
    t.xd = xd; t.xv = xv; t.xc = xc; t.xf = xf; t.xr = xr;
    tbl.push_back(t);
  endfunction
  function automatic bit is_dup(int d);
`ifdef DIGIT_UNIQUE_EN
    foreach (q[i]) if (q[i] == d) return 1'b1;
`endif
    return 1'b0;
  endfunction
  function automatic void model(logic r, e, v, logic [3:0] d, logic b, cl, cm, rd);
    if (r) begin
      q.delete(); m_hold = 0; m_rej = 0;
    end else if (!e) begin
      m_rej = 0;
    end else if (m_hold) begin
      m_rej = !rd && (v || b || cm);
      if (rd) begin q.delete(); m_hold = 0; end
    end else begin
      m_rej = 0;
      if (cl) q.delete();
      else if (b) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (v && q.size() == D) begin
        m_rej = 1; m_hold = cm;
      end else if (v) begin
        if (int'(d) <= 9 && !is_dup(int'(d))) q.push_back(int'(d));
        else m_rej = 1;
      end else if (cm) begin
        if (q.size() == D) m_hold = 1;
        else m_rej = 1;
      end
    end
  endfunction
  function automatic logic [15:0] exp_digits();
    logic [15:0] r = '1;
    foreach (q[i]) r[i*W +: W] = q[i][3:0];
    return r;
  endfunction
  initial begin
    //   name       r  e  v  d    b  cl cm rd  digits   v  cnt f  rej
    add("reset",    1, 1, 0, 0,   0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    add("d1",       0, 1, 1, 1,   0, 0, 0, 0, 16'hFFF1, 0, 1, 0, 0);
    add("d2",       0, 1, 1, 2,   0, 0, 0, 0, 16'hFF21, 0, 2, 0, 0);
    add("d3",       0, 1, 1, 3,   0, 0, 0, 0, 16'hF321, 0, 3, 0, 0);
    add("d4",       0, 1, 1, 4,   0, 0, 0, 0, 16'h4321, 0, 4, 1, 0);
    add("fifth",    0, 1, 1, 5,   0, 0, 0, 0, 16'h4321, 0, 4, 1, 1);
    add("rej_end",  0, 1, 0, 0,   0, 0, 0, 0, 16'h4321, 0, 4, 1, 0);
    add("clear",    0, 1, 0, 0,   0, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    add("d7",       0, 1, 1, 7,   0, 0, 0, 0, 16'hFFF7, 0, 1, 0, 0);
    add("d8",       0, 1, 1, 8,   0, 0, 0, 0, 16'hFF87, 0, 2, 0, 0);
    add("back",     0, 1, 0, 0,   1, 0, 0, 0, 16'hFFF7, 0, 1, 0, 0);
    add("d9",       0, 1, 1, 9,   0, 0, 0, 0, 16'hFF97, 0, 2, 0, 0);
    add("clear2",   0, 1, 0, 0,   0, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    add("f1",       0, 1, 1, 1,   0, 0, 0, 0, 16'hFFF1, 0, 1, 0, 0);
    add("f2",       0, 1, 1, 2,   0, 0, 0, 0, 16'hFF21, 0, 2, 0, 0);
    add("f3",       0, 1, 1, 3,   0, 0, 0, 0, 16'hF321, 0, 3, 0, 0);
    add("f4",       0, 1, 1, 4,   0, 0, 0, 0, 16'h4321, 0, 4, 1, 0);
    add("commit",   0, 1, 0, 0,   0, 0, 1, 0, 16'h4321, 1, 4, 1, 0);
    add("hold1",    0, 1, 0, 0,   0, 0, 0, 0, 16'h4321, 1, 4, 1, 0);
    add("hold_v",   0, 1, 1, 2,   0, 0, 0, 0, 16'h4321, 1, 4, 1, 1);
    add("hold_cl",  0, 1, 0, 0,   0, 1, 0, 0, 16'h4321, 1, 4, 1, 0);
    add("release",  0, 1, 0, 0,   0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0);
    add("g1",       0, 1, 1, 1,   0, 0, 0, 0, 16'hFFF1, 0, 1, 0, 0);
    add("g2",       0, 1, 1, 2,   0, 0, 0, 0, 16'hFF21, 0, 2, 0, 0);
    add("g3",       0, 1, 1, 3,   0, 0, 0, 0, 16'hF321, 0, 3, 0, 0);
    add("cl_b_v",   0, 1, 1, 5,   1, 1, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    add("range",    0, 1, 1, 10,  0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 1);
    add("cm_fill",  0, 1, 0, 0,   0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 1);
    add("ce_off",   0, 0, 1, 2,   0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    add("back0",    0, 1, 0, 0,   1, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0);
    add("h1",       0, 1, 1, 5,   0, 0, 0, 0, 16'hFFF5, 0, 1, 0, 0);
    add("h2",       0, 1, 1, 6,   0, 0, 0, 0, 16'hFF65, 0, 2, 0, 0);
    add("h3",       0, 1, 1, 7,   0, 0, 0, 0, 16'hF765, 0, 3, 0, 0);
    add("h4",       0, 1, 1, 8,   0, 0, 0, 0, 16'h8765, 0, 4, 1, 0);
    add("back_ful", 0, 1, 0, 0,   1, 0, 0, 0, 16'hF765, 0, 3, 0, 0);
    add("h4b",      0, 1, 1, 0,   0, 0, 0, 0, 16'h0765, 0, 4, 1, 0);
    add("commit2",  0, 1, 0, 0,   0, 0, 1, 0, 16'h0765, 1, 4, 1, 0);
    add("rst_hold", 1, 0, 0, 0,   0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].cl, tbl[i].cm, tbl[i].rd);
      check(tbl[i].nm, tbl[i].xd, tbl[i].xv, tbl[i].xc, tbl[i].xf, tbl[i].xr);
    end
    drive(0, 1, 1, 3, 0, 0, 0, 0);
    check("dup_a", 16'hFFF3, 0, 1, 0, 0);
    drive(0, 1, 1, 3, 0, 0, 0, 0);
`ifdef DIGIT_UNIQUE_EN
    check("dup_b", 16'hFFF3, 0, 1, 0, 1);
`else
    check("dup_b", 16'hFF33, 0, 2, 0, 0);
`endif
    drive(0, 1, 1, 11, 0, 0, 0, 0);
    drive(0, 0, 1, 11, 0, 0, 0, 0);
`ifdef DIGIT_UNIQUE_EN
    check("ce_rej_low", 16'hFFF3, 0, 1, 0, 0);
`else
    check("ce_rej_low", 16'hFF33, 0, 2, 0, 0);
`endif
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    model(1, 1, 0, 0, 0, 0, 0, 0);
    check("rand_reset", exp_digits(), m_hold, 3'(q.size()), q.size() == D, m_rej);
    for (int n = 0; n < 3000; n++) begin
      logic r, e, v, b, cl, cm, rd;
      logic [3:0] d;
      r = $urandom_range(0, 199) == 0;
      e = $urandom_range(0, 7) != 0;
      v = $urandom_range(0, 1) == 1;
      d = 4'($urandom_range(0, 11));
      b = $urandom_range(0, 9) == 0;
      cl = $urandom_range(0, 19) == 0;
      cm = $urandom_range(0, 3) == 0;
      rd = $urandom_range(0, 3) == 0;
      drive(r, e, v, d, b, cl, cm, rd);
      model(r, e, v, d, b, cl, cm, rd);
      check("rand", exp_digits(), m_hold, 3'(q.size()), q.size() == D, m_rej);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule

// File: doc/digit_entry_buffer.md
Name: digit_entry_buffer

Overview:
- Parametrised successor to the 4-slot round-robin digit collector.
- Collects DIGITS input digits of DW bits each into ordered slots; supports backspace, clear and range checking.
- Full guess is released downstream through a valid/ready commit handshake.
- Sits between the keypad/switch decoder and the game compare logic.

Parameters:
DIGITS, 4, number of digit slots (2..8)
DW, 4, bits per digit
MAX_DIGIT, 9, largest accepted digit value; larger values are rejected
INIT_VAL, all-ones (2**DW-1), value loaded into empty slots

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
ce  input  1  clock enable; when low, all state holds
in_valid  input  1  one-cycle strobe, in_digit is a new entry
in_digit  input  DW  digit value
in_back  input  1  backspace strobe: remove last entered digit
in_clear  input  1  clear strobe: empty all slots
commit  input  1  request to release the current guess
out_ready  input  1  downstream accepts the guess
out_digits  output  DIGITS*DW  slot k at bits [k*DW +: DW]; slot 0 is the first digit entered
out_valid  output  1  guess held and offered downstream
count  output  clog2(DIGITS+1)  number of filled slots
full  output  1  count == DIGITS
reject  output  1  one-cycle pulse: entry refused

Behaviour:
- Synchronous active-high reset, as already decided; rst on a clk rising edge wins over everything, including ce=0.
- Reset values:
  - every slot = INIT_VAL
  - count = 0, full = 0, out_valid = 0, reject = 0
  - state = FILL
- All outputs are registered; every action takes effect on the edge where ce=1.
- When ce=0: state, slots, count and out_valid hold; reject is driven 0.
- State FILL (count < DIGITS):
  - Same-cycle priority is in_clear > in_back > in_valid; lower-priority strobes in that cycle are ignored.
  - in_clear: all slots = INIT_VAL, count = 0.
  - in_back with count > 0: slot[count-1] = INIT_VAL, count decrements. With count = 0 it is a no-op with no reject.
  - in_valid with in_digit <= MAX_DIGIT: slot[count] = in_digit, count increments. If count reaches DIGITS, go to FULL.
  - in_valid with in_digit > MAX_DIGIT: slots unchanged, reject = 1 for one cycle.
  - commit in FILL: ignored, reject = 1.
- State FULL (count == DIGITS):
  - in_clear and in_back behave as in FILL; in_back returns to FILL.
  - in_valid: no write, reject = 1; there is no wrap-around.
  - commit (no clear/back in the same cycle): out_valid = 1 on the next edge, go to HOLD.
- State HOLD:
  - out_digits stable, out_valid = 1.
  - in_valid, in_back, commit: ignored, reject = 1 for each cycle one is asserted. in_clear is also ignored.
  - out_valid & out_ready & ce: on that edge out_valid = 0, all slots = INIT_VAL, count = 0, go to FILL. The next cycle is ready for a new entry.
  - out_ready alone, or out_ready with out_valid=0, has no effect.
- full is a registered copy of (count == DIGITS).
- reject never asserts on the same edge as a slot write.
- Reset mid-HOLD drops out_valid immediately at that edge, with no handshake; downstream must tolerate this.

Optional Feature:
- Macro: DIGIT_UNIQUE_EN.
- Defined: an in_valid whose in_digit equals any already-filled slot (index < count) is refused (no write, reject = 1). This enforces the no-repeated-digit rule for secrets and guesses. Empty slots holding INIT_VAL are never compared.
- Undefined: duplicate digits are accepted; no comparator logic is built.

Test Plan:
1. Reset, then in_valid digits 1,2,3,4 -> out_digits = 0x4321, count 4, full 1; a 5th in_valid 5 -> reject pulse, slots unchanged.
2. Enter 7,8; in_back -> count 1, slot1 = 0xF; in_valid 9 -> out_digits = 0xFF97.
3. Fill 1,2,3,4, commit with out_ready=0 for 3 cycles -> out_valid held, data 0x4321; out_ready=1 -> out_valid drops next edge, slots all 0xF, count 0.
4. Same cycle in_clear=1, in_back=1, in_valid=1 with count 3 -> only the clear takes effect, count 0, no reject; in_digit 0xA -> reject, count unchanged.
5. ce=0 while in_valid=1 and commit=1 -> no state change, no reject; rst=1 during HOLD -> out_valid 0, slots 0xF, count 0 at that edge.
6. With DIGIT_UNIQUE_EN defined: enter 3, then 3 -> reject, count 1. Without the macro -> accepted, out_digits = 0xFF33. Repeat with DIGITS=6, DW=4 to check widths.
